// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE block builder.
//   SHAKE_RATE   : rate in bits (21 lanes of 64 bits)
//   SHAKE_LANE_W : lane width in bits
//   SHAKE_SUFFIX : domain-separation suffix, first pad bit included
//   blk_state_t  : builder state encoding
package shake_pkg;

  localparam int SHAKE_RATE = 1344;
  localparam int SHAKE_LANE_W = 64;
  localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    PAD_ONLY
  } blk_state_t;

endpackage

// File: rtl/shake_block_builder_if.sv
// Lane input stream and block output stream of the SHAKE block builder.
//   master : message source / absorb stage side (testbench or upstream logic)
//   slave  : the builder itself
//   in_valid/in_ready/in_data/in_last/in_last_bytes : 64-bit lane stream
//   blk_valid/blk_ready/blk_data/blk_last          : R-bit rate block stream
interface shake_block_builder_if
  import shake_pkg::*;
#(
  parameter int R = SHAKE_RATE
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [SHAKE_LANE_W-1:0] in_data;
  logic                    in_last;
  logic [3:0]              in_last_bytes;
  logic                    blk_valid;
  logic                    blk_ready;
  logic [R-1:0]            blk_data;
  logic                    blk_last;

  modport master (
    output in_valid, in_data, in_last, in_last_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_last_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

endinterface

// File: rtl/shake_block_builder_padding.sv
// SHAKE pad generator: the suffix byte placed at bit offset len (byte
// aligned) and the final pad bit at R-1. Purely combinational.
//   len : number of message bits already in the block (0 for a pad-only block)
//   pad : R-bit pad pattern to OR onto the block
module padding #(
  parameter int         R      = 1344,
  parameter logic [7:0] SUFFIX = 8'h1F
) (
  input  logic [10:0]  len,
  output logic [R-1:0] pad
);

  always_comb begin
    pad = {{(R-8){1'b0}}, SUFFIX} << len;
    pad[R-1] = 1'b1;
  end

endmodule

// File: rtl/shake_block_builder.sv
// Packs a lane stream into padded R-bit SHAKE rate blocks.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : lane input stream and block output stream
//   blk_count   : 16-bit block handshake counter, present only when the
//                 SHAKE_BLK_COUNT_EN macro is defined
// A message that exactly fills a block is followed by a pad-only block.
module shake_block_builder
  import shake_pkg::*;
#(
  parameter int         R      = SHAKE_RATE,
  parameter logic [7:0] SUFFIX = SHAKE_SUFFIX
) (
  input  logic                 clk,
  input  logic                 rst,
  shake_block_builder_if.slave bus
`ifdef SHAKE_BLK_COUNT_EN
  ,
  output logic [15:0]          blk_count
`endif
);

  localparam int NL = R / SHAKE_LANE_W;
  localparam int LW = $clog2(NL);
  localparam logic [LW-1:0] LAST_LANE = LW'(NL - 1);
  localparam logic [10:0] R_BITS = 11'(R);

  blk_state_t state_reg, state_next;
  logic [10:0]   len_reg;
  logic [LW-1:0] lane_cnt_reg;
  logic          final_reg;
  logic          pad_pend_reg;

  logic [R-1:0]  buf_flat;
  logic [R-1:0]  pad_vec;
  logic [10:0]   pad_len;
  logic          in_ready_int, blk_valid_int, blk_last_int;
  logic [R-1:0]  blk_data_int;
  logic          lane_fire, buf_clear;
  logic [3:0]    lane_bytes;
  logic [10:0]   len_sum;
  logic [63:0]   lane_data;

  // Keeps bytes [0, nbytes) of a lane; nbytes is already clamped to 8.
  function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  assign lane_fire = bus.in_valid & in_ready_int;
  assign buf_clear = (state_reg == HOLD) & bus.blk_ready;

  always_comb begin
    lane_bytes = 4'd8;
    if (bus.in_last) begin
      lane_bytes = (bus.in_last_bytes > 4'd8) ? 4'd8 : bus.in_last_bytes;
    end
  end

  assign len_sum   = len_reg + {4'b0, lane_bytes, 3'b000};
  assign lane_data = bus.in_data & byte_mask(lane_bytes);

  // One register per lane; lane_cnt selects which one a handshake loads.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [63:0] lane_reg;
      always_ff @(posedge clk) begin
        if (rst || buf_clear) begin
          lane_reg <= '0;
        end else if (lane_fire && lane_cnt_reg == LW'(gi)) begin
          lane_reg <= lane_data;
        end
      end
      assign buf_flat[gi*64 +: 64] = lane_reg;
    end
  endgenerate

  padding #(.R(R), .SUFFIX(SUFFIX)) u_padding (
    .len (pad_len),
    .pad (pad_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= FILL;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    in_ready_int  = 1'b0;
    blk_valid_int = 1'b0;
    blk_last_int  = 1'b0;
    blk_data_int  = '0;
    pad_len       = '0;
    case (state_reg)
      FILL: begin
        in_ready_int = 1'b1;
        if (lane_fire && (bus.in_last || lane_cnt_reg == LAST_LANE)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        blk_valid_int = 1'b1;
        pad_len       = len_reg;
        blk_data_int  = buf_flat | (final_reg ? pad_vec : '0);
        blk_last_int  = final_reg;
        if (bus.blk_ready) state_next = pad_pend_reg ? PAD_ONLY : FILL;
      end
      PAD_ONLY: begin
        blk_valid_int = 1'b1;
        blk_data_int  = pad_vec;
        blk_last_int  = 1'b1;
        if (bus.blk_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Length bookkeeping. A last lane that lands exactly on R cannot carry
  // the suffix, so the pad goes into a following pad-only block.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg      <= '0;
      lane_cnt_reg <= '0;
      final_reg    <= 1'b0;
      pad_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (lane_fire) begin
            len_reg      <= len_sum;
            lane_cnt_reg <= lane_cnt_reg + 1'b1;
            if (bus.in_last) begin
              final_reg    <= (len_sum != R_BITS);
              pad_pend_reg <= (len_sum == R_BITS);
            end else if (lane_cnt_reg == LAST_LANE) begin
              final_reg    <= 1'b0;
              pad_pend_reg <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.blk_ready) begin
            len_reg      <= '0;
            lane_cnt_reg <= '0;
          end
        end
        PAD_ONLY: begin
          if (bus.blk_ready) pad_pend_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced idle while reset is held.
  assign bus.in_ready  = in_ready_int & ~rst;
  assign bus.blk_valid = blk_valid_int & ~rst;
  assign bus.blk_last  = blk_last_int & ~rst;
  assign bus.blk_data  = rst ? '0 : blk_data_int;

`ifdef SHAKE_BLK_COUNT_EN
  logic blk_fire;
  assign blk_fire = blk_valid_int & bus.blk_ready;

  always_ff @(posedge clk) begin
    if (rst)           blk_count <= '0;
    else if (blk_fire) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shake_block_builder.sv
module tb_shake_block_builder;
  import shake_pkg::*;

  localparam int R  = SHAKE_RATE;
  localparam int RB = R / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shake_block_builder_if #(.R(R)) bus ();

`ifdef SHAKE_BLK_COUNT_EN
  logic [15:0] blk_count;
`endif

  shake_block_builder #(.R(R), .SUFFIX(8'h1F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHAKE_BLK_COUNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  byte unsigned msg_q[$];
  logic [R-1:0] exp_data_q[$];
  bit           exp_last_q[$];
  logic [R-1:0] got_data_q[$];
  bit           got_last_q[$];

  typedef struct {
    int nbytes;
    int lb_force;    // -1: natural last-lane byte count
    int exp_blocks;
    int suffix_bit;  // first suffix bit in the final block
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
    int fb;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      fb = -1;
      for (int i = 0; i < R; i++) begin
        if (act[i] !== exp[i]) begin
          fb = i;
          break;
        end
      end
      $display("FAIL %s: block got != expected, first bad bit %0d got %b expected %b",
               name, fb, act[fb], exp[fb]);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic make_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: every full 168-byte chunk is a raw block; the remainder
  // (possibly empty) becomes the final block with suffix 0x1F at byte
  // 'rem' and the top rate bit set.
  task automatic build_model();
    int n, full, rem;
    logic [R-1:0] b;
    n = msg_q.size();
    full = n / RB;
    exp_data_q.delete();
    exp_last_q.delete();
    for (int k = 0; k < full; k++) begin
      b = '0;
      for (int i = 0; i < RB; i++) b[8*i +: 8] = msg_q[k*RB + i];
      exp_data_q.push_back(b);
      exp_last_q.push_back(1'b0);
    end
    rem = n - full * RB;
    b = '0;
    for (int i = 0; i < rem; i++) b[8*i +: 8] = msg_q[full*RB + i];
    b[8*rem +: 8] = b[8*rem +: 8] | 8'h1F;
    b[R-1] = 1'b1;
    exp_data_q.push_back(b);
    exp_last_q.push_back(1'b1);
  endtask

  task automatic drive_msg(input int lb_force, input bit gaps);
    int n, nl, idx, t;
    logic [63:0] d;
    n = msg_q.size();
    nl = (n == 0) ? 1 : (n + 7) / 8;
    for (int l = 0; l < nl; l++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      for (int k = 0; k < 8; k++) begin
        idx = 8*l + k;
        d[8*k +: 8] = (idx < n) ? msg_q[idx] : 8'($urandom);
      end
      bus.in_data = d;
      bus.in_last = (l == nl - 1);
      if (l == nl - 1) bus.in_last_bytes = (lb_force >= 0) ? 4'(lb_force) : 4'(n - 8*l);
      else             bus.in_last_bytes = 4'($urandom);
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) fail("lane_accept");
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // mode 0: random blk_ready, 1: always ready, 2: first block stalled 10 cycles
  task automatic collect(input int mode);
    int cyc, stall;
    bit done, r;
    logic [R-1:0] held;
    cyc = 0; stall = 0; done = 1'b0; held = '0;
    got_data_q.delete();
    got_last_q.delete();
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      r = 1'b0;
      if (bus.blk_valid) begin
        check("in_ready_low_while_block", 64'(bus.in_ready), 64'd0);
        case (mode)
          0: r = 1'($urandom_range(0, 1));
          1: r = 1'b1;
          default: begin
            if (stall < 10) begin
              if (stall == 0) held = bus.blk_data;
              else check_blk("stall_data_stable", bus.blk_data, held);
              stall++;
            end else begin
              r = 1'b1;
            end
          end
        endcase
        if (r) begin
          got_data_q.push_back(bus.blk_data);
          got_last_q.push_back(bus.blk_last);
          if (bus.blk_last) done = 1'b1;
        end
      end
      bus.blk_ready = r;
    end
    if (!done) fail("block_wait");
    @(negedge clk);
    bus.blk_ready = 1'b0;
  endtask

  task automatic run_msg(input int lb_force, input bit gaps, input int mode);
    int m;
    build_model();
    fork
      drive_msg(lb_force, gaps);
      collect(mode);
    join
    check("block_count", 64'(got_data_q.size()), 64'(exp_data_q.size()));
    m = (got_data_q.size() < exp_data_q.size()) ? got_data_q.size() : exp_data_q.size();
    for (int i = 0; i < m; i++) begin
      check_blk($sformatf("blk%0d_data", i), got_data_q[i], exp_data_q[i]);
      check($sformatf("blk%0d_last", i), 64'(got_last_q[i]), 64'(exp_last_q[i]));
    end
    $display("msg %0d bytes gaps=%0d mode=%0d: %0d blocks received, %0d expected",
             msg_q.size(), gaps, mode, got_data_q.size(), exp_data_q.size());
  endtask

  // Pushes k non-last random lanes.
  task automatic push_lanes(input int k);
    int t;
    for (int i = 0; i < k; i++) begin
      bus.in_data  = {$urandom, $urandom};
      bus.in_last  = 1'b0;
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) fail("push_lane");
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [R-1:0] fb;

    tbl[0] = '{34,  -1, 1, 272};
    tbl[1] = '{0,   -1, 1, 0};
    tbl[2] = '{168, -1, 2, 0};
    tbl[3] = '{200, -1, 2, 256};
    tbl[4] = '{8,   -1, 1, 64};
    tbl[5] = '{167, -1, 1, 1336};
    tbl[6] = '{336, -1, 3, 0};
    tbl[7] = '{16,  12, 1, 128};

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_last_bytes = '0;
    bus.blk_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("rst_blk_last", 64'(bus.blk_last), 64'd0);
    check_blk("rst_blk_data", bus.blk_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef SHAKE_BLK_COUNT_EN
    check("blk_count_after_rst", 64'(blk_count), 64'd0);
`endif

    // Table-driven directed messages
    for (int v = 0; v < 8; v++) begin
      make_msg(tbl[v].nbytes);
      run_msg(tbl[v].lb_force, 1'b0, 1);
      check($sformatf("tbl%0d_nblocks", v), 64'(got_data_q.size()), 64'(tbl[v].exp_blocks));
      if (got_data_q.size() > 0) begin
        fb = got_data_q[got_data_q.size() - 1];
        check($sformatf("tbl%0d_suffix", v), 64'(fb[tbl[v].suffix_bit +: 5]), 64'h1F);
        check($sformatf("tbl%0d_top_bit", v), 64'(fb[R-1]), 64'd1);
      end
    end

    // 200-byte message with a 10-cycle stall, then the same message with
    // random gaps and random ready
    make_msg(200);
    run_msg(-1, 1'b1, 2);
    run_msg(-1, 1'b1, 0);

    // Reset after 3 lanes: nothing emitted, next message is clean
    push_lanes(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_msg_no_block", 64'(bus.blk_valid), 64'd0);
    end
    make_msg(34);
    run_msg(-1, 1'b0, 1);

    // Reset during HOLD: block is valid one cycle after the completing lane,
    // then discarded
    push_lanes(21);
    check("hold_latency_valid", 64'(bus.blk_valid), 64'd1);
    check("hold_last_low", 64'(bus.blk_last), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_hold_no_block", 64'(bus.blk_valid), 64'd0);
    end
    check("rst_mid_hold_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef SHAKE_BLK_COUNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("blk_count_zero", 64'(blk_count), 64'd0);
    make_msg(200);
    run_msg(-1, 1'b0, 1);
    check("blk_count_200B", 64'(blk_count), 64'd2);
`endif

    // Randomised messages against the reference model
    for (int it = 0; it < 20; it++) begin
      make_msg($urandom_range(0, 400));
      run_msg(-1, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shake_block_builder.md
# shake_block_builder

Packs a streamed message, 64-bit lane by lane, into R-bit rate blocks for the SHAKE sponge. It sits directly upstream of the Keccak absorb/permutation stage. It owns the message-length bookkeeping and instantiates `padding` to apply the SHAKE suffix and final pad bit to the last block, inserting a pad-only block when the message exactly fills a block. Each output block is a complete, already padded rate block that the absorb stage XORs straight into state.

## Interface
Parameters:
- `R`, 1344: rate in bits; must be a multiple of 64 (1344 gives 21 lanes).
- `SUFFIX`, 8'h1F: domain-separation suffix passed to `padding`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  lane valid.
- `in_ready`  out  1  builder can accept a lane.
- `in_data`  in  64  lane data, little-endian; byte 0 is `in_data[7:0]`.
- `in_last`  in  1  this lane is the last lane of the message.
- `in_last_bytes`  in  4  valid bytes in the last lane, 0..8; ignored unless `in_last`.
- `blk_valid`  out  1  output block valid.
- `blk_ready`  in  1  absorb stage accepts the block.
- `blk_data`  out  R  rate block, padded if `blk_last`.
- `blk_last`  out  1  final (padded) block of the message.

## Operation
- States: `FILL`, `HOLD`, `PAD_ONLY`.
- **FILL**
  - `in_ready`=1.
  - Lane handshake (`in_valid & in_ready`) writes `in_data` into `buf[64*lane_cnt +: 64]`.
  - On a last lane, bytes at index ≥ `in_last_bytes` are zeroed.
  - `len` (11 bits, bits in the current block) increases by 64, or by `8*in_last_bytes` on the last lane.
  - `lane_cnt` increments after each lane.
- **Transitions out of FILL**
  - Lane `R/64-1` accepted, not last → `HOLD` with `final`=0.
  - Last lane accepted and resulting `len` < R → `HOLD` with `final`=1.
  - Last lane accepted and `len` == R → `HOLD` with `final`=0 and `pad_pend`=1.
- **HOLD**
  - `blk_valid`=1.
  - `blk_data` = `buf` | (`final` ? `padding(len)` : 0).
  - `blk_last` = `final`.
  - On `blk_ready`: clear `buf`, `len`, `lane_cnt`.
  - Next state: `PAD_ONLY` if `pad_pend`, otherwise `FILL`.
- **PAD_ONLY**
  - `blk_valid`=1, `blk_data` = `padding(0)` (bits 0..4 and bit R-1 set), `blk_last`=1.
  - On `blk_ready`: clear `pad_pend` → `FILL`.
- **Empty message**: a single lane with `in_last`=1 and `in_last_bytes`=0 produces one block = `padding(0)` with `blk_last`=1.
- **Out-of-range `in_last_bytes`**: values > 8 are treated as 8.
- **Contiguity**: messages are back-to-back; the first lane after a `blk_last` block begins a new message.

## Timing
- Reset values: `in_ready`=0 while `rst`=1, `blk_valid`=0, `blk_last`=0, `blk_data`=0. State returns to `FILL` with all counters, `buf` and `pad_pend` cleared.
- `in_ready` is combinational from the state only; it never depends on `in_valid`.
- Throughput: one lane per cycle in `FILL`.
- Latency: `blk_valid` rises the cycle after the handshake of the completing lane.
- `blk_data` and `blk_last` are stable while `blk_valid`=1 and `blk_ready`=0.
- On a block handshake the builder is back in `FILL` (or `PAD_ONLY`) on the next cycle; there is one bubble cycle per block.
- `in_ready`=0 throughout `HOLD` and `PAD_ONLY`. Lanes presented then are not consumed.
- Reset mid-message or mid-`HOLD`: the partial block is discarded and no block is emitted.
- `padding` is purely combinational on `len`. The suffix always fits because `len` is byte-aligned and ≤ R-8 when `final`=1.

## Configuration
- `SHAKE_BLK_COUNT_EN`
  - Defined: adds output `blk_count`, 16 bits.
    - Reset to 0.
    - Incremented on every block handshake, pad-only blocks included.
    - Wraps at 2^16.
  - Undefined: port and counter absent; all other behaviour is identical.

## Structure
- Shared package `shake_pkg`:
  - `SHAKE_RATE` (1344), `SHAKE_LANE_W` (64), `SHAKE_SUFFIX` (8'h1F).
  - Builder state enum `blk_state_t`.
- One sub-module: `padding`, instantiated once with `R` and driven by `len` (or 0 in `PAD_ONLY`).
- The byte-mask for the last lane is a local function; no further sub-modules.

## Test plan
- 34-byte seed (5 lanes, last with `in_last_bytes`=2) → one block; message bits 0..271 equal input, bits 272..276 =1, bit 1343 =1, `blk_last`=1.
- Empty message (`in_last_bytes`=0) → one block, value = bits {0,1,2,3,4,1343} set, `blk_last`=1.
- 168-byte message (21 full lanes, last `in_last_bytes`=8) → block 1 raw data with `blk_last`=0, then pad-only block identical to the empty case with `blk_last`=1.
- 200-byte message → block 1 unpadded; block 2 holds 32 bytes, bits 256..260 set, bit 1343 set, `blk_last`=1.
- `blk_ready` held low 10 cycles in `HOLD` → `blk_data` constant, `in_ready`=0, no lane lost; random `in_valid` gaps produce identical output.
- `rst` asserted after 3 lanes → `blk_valid` stays 0; the next 34-byte message yields exactly the first scenario's block. With `SHAKE_BLK_COUNT_EN`, `blk_count` reads 0 after reset and 2 after the 200-byte case.
